// File: rtl/idma_reg_mchan_frontend.sv
// Multi-channel iDMA register frontend: per-channel descriptor queues fed by next_id
// reads, round-robin issue to the backend and in-order completion tracking.
module idma_reg_mchan_frontend #(
  parameter int NumChannels   = 4,
  parameter int QueueDepth    = 2,
  parameter int InflightDepth = 4,
  parameter int IdWidth       = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   reg_valid_i,
  input  logic                   reg_write_i,
  input  logic [11:0]            reg_addr_i,
  input  logic [63:0]            reg_wdata_i,
  input  logic [7:0]             reg_wstrb_i,
  output logic [63:0]            reg_rdata_o,
  output logic                   reg_error_o,
  output logic                   reg_ready_o,
  output logic                   burst_valid_o,
  input  logic                   burst_ready_i,
  output logic [63:0]            burst_src_addr_o,
  output logic [63:0]            burst_dst_addr_o,
  output logic [63:0]            burst_length_o,
  output logic                   burst_decouple_o,
  output logic                   burst_deburst_o,
  output logic [3:0]             burst_axi_id_o,
  input  logic                   trans_complete_i,
  output logic [NumChannels-1:0] busy_o
);
  localparam int ChW   = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int QPtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int QCntW = $clog2(QueueDepth + 1);
  localparam int FPtrW = (InflightDepth > 1) ? $clog2(InflightDepth) : 1;
  localparam int FCntW = $clog2(InflightDepth + 1);

  typedef struct packed {
    logic [63:0]        src;
    logic [63:0]        dst;
    logic [63:0]        len;
    logic [1:0]         conf;
    logic [IdWidth-1:0] id;
  } desc_t;

  logic [63:0]              src_q     [NumChannels];
  logic [63:0]              dst_q     [NumChannels];
  logic [63:0]              len_q     [NumChannels];
  logic [1:0]               conf_q    [NumChannels];
  logic [IdWidth-1:0]       next_id_q [NumChannels];
  logic [IdWidth-1:0]       done_q    [NumChannels];

  desc_t                    qmem      [NumChannels][QueueDepth];
  logic [QPtrW-1:0]         q_rd      [NumChannels];
  logic [QPtrW-1:0]         q_wr      [NumChannels];
  logic [QCntW-1:0]         q_cnt     [NumChannels];
  logic [NumChannels-1:0]   q_push;
  logic [NumChannels-1:0]   q_pop;

  logic [ChW-1:0]           f_ch      [InflightDepth];
  logic [InflightDepth-1:0] f_vld;
  logic [FPtrW-1:0]         f_rd;
  logic [FPtrW-1:0]         f_wr;
  logic [FCntW-1:0]         f_cnt;

  logic [ChW-1:0]           rr_ptr;
  logic [ChW-1:0]           rr_ch;
  logic                     rr_found;
  logic                     hold_q;
  logic [ChW-1:0]           hold_ch_q;
  logic [ChW-1:0]           gnt_ch;
  logic                     hs;
  logic                     cpl;

  logic [5:0]               ch_idx;
  logic [2:0]               offs;
  logic [ChW-1:0]           sel;
  logic                     req_err;
  logic                     wr_en;
  logic                     rd_en;
  logic                     sel_full;
  logic                     id_push;

  function automatic logic [63:0] apply_strb(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  strb);
    logic [63:0] r;
    r = old_v;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  // IDs never take the value 0, so 0 can mean "nothing issued/completed yet".
  function automatic logic [IdWidth-1:0] id_inc(input logic [IdWidth-1:0] v);
    return (v == '1) ? IdWidth'(1) : v + IdWidth'(1);
  endfunction

  function automatic logic [QPtrW-1:0] q_inc(input logic [QPtrW-1:0] p);
    return (p == QPtrW'(QueueDepth - 1)) ? '0 : p + QPtrW'(1);
  endfunction

  function automatic logic [FPtrW-1:0] f_inc(input logic [FPtrW-1:0] p);
    return (p == FPtrW'(InflightDepth - 1)) ? '0 : p + FPtrW'(1);
  endfunction

  assign ch_idx      = reg_addr_i[11:6];
  assign offs        = reg_addr_i[5:3];
  assign sel         = ch_idx[ChW-1:0];
  assign reg_ready_o = 1'b1;

  assign req_err  = reg_valid_i && ((reg_addr_i[2:0] != 3'd0) || (int'(ch_idx) >= NumChannels) ||
                                    (offs == 3'd7) || (reg_write_i && (offs >= 3'd4)));
  assign wr_en    = reg_valid_i && reg_write_i && !req_err;
  assign rd_en    = reg_valid_i && !reg_write_i && !req_err;
  assign sel_full = (q_cnt[sel] == QCntW'(QueueDepth));
  assign id_push  = rd_en && (offs == 3'd5) && (len_q[sel] != '0) && !sel_full;
  assign reg_error_o = req_err;

  always_comb begin
    reg_rdata_o = '0;
    if (rd_en) begin
      case (offs)
        3'd0:    reg_rdata_o = src_q[sel];
        3'd1:    reg_rdata_o = dst_q[sel];
        3'd2:    reg_rdata_o = len_q[sel];
        3'd3:    reg_rdata_o = {62'd0, conf_q[sel]};
        3'd4:    reg_rdata_o = {55'd0, sel_full, 4'(q_cnt[sel]), 3'd0, busy_o[sel]};
        3'd5:    reg_rdata_o = id_push ? 64'(next_id_q[sel]) : '0;
        3'd6:    reg_rdata_o = 64'(done_q[sel]);
        default: reg_rdata_o = '0;
      endcase
    end
  end

  always_comb begin : rr_pick
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_ch    = '0;
    for (int i = 0; i < NumChannels; i++) begin
      idx = (int'(rr_ptr) + i) % NumChannels;
      if (!rr_found && (q_cnt[idx] != '0)) begin
        rr_found = 1'b1;
        rr_ch    = ChW'(idx);
      end
    end
  end

  // A grant offered without ready is frozen in hold_ch_q until the handshake.
  assign gnt_ch        = hold_q ? hold_ch_q : rr_ch;
  assign burst_valid_o = (hold_q || rr_found) && (f_cnt < FCntW'(InflightDepth));
  assign hs            = burst_valid_o && burst_ready_i;
  assign cpl           = trans_complete_i && (f_cnt != '0);

  assign burst_src_addr_o = qmem[gnt_ch][q_rd[gnt_ch]].src;
  assign burst_dst_addr_o = qmem[gnt_ch][q_rd[gnt_ch]].dst;
  assign burst_length_o   = qmem[gnt_ch][q_rd[gnt_ch]].len;
  assign burst_decouple_o = qmem[gnt_ch][q_rd[gnt_ch]].conf[0];
  assign burst_deburst_o  = qmem[gnt_ch][q_rd[gnt_ch]].conf[1];
  assign burst_axi_id_o   = 4'(gnt_ch);

  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      q_push[c] = id_push && (sel == ChW'(c));
      q_pop[c]  = hs && (gnt_ch == ChW'(c));
      busy_o[c] = (q_cnt[c] != '0);
      for (int k = 0; k < InflightDepth; k++) begin
        if (f_vld[k] && (f_ch[k] == ChW'(c))) busy_o[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NumChannels; c++) begin
        src_q[c]     <= '0;
        dst_q[c]     <= '0;
        len_q[c]     <= '0;
        conf_q[c]    <= '0;
        next_id_q[c] <= IdWidth'(1);
        done_q[c]    <= '0;
        q_rd[c]      <= '0;
        q_wr[c]      <= '0;
        q_cnt[c]     <= '0;
        for (int d = 0; d < QueueDepth; d++) qmem[c][d] <= '0;
      end
      for (int k = 0; k < InflightDepth; k++) f_ch[k] <= '0;
      f_vld     <= '0;
      f_rd      <= '0;
      f_wr      <= '0;
      f_cnt     <= '0;
      rr_ptr    <= '0;
      hold_q    <= 1'b0;
      hold_ch_q <= '0;
    end else begin
      if (wr_en) begin
        case (offs)
          3'd0:    src_q[sel] <= apply_strb(src_q[sel], reg_wdata_i, reg_wstrb_i);
          3'd1:    dst_q[sel] <= apply_strb(dst_q[sel], reg_wdata_i, reg_wstrb_i);
          3'd2:    len_q[sel] <= apply_strb(len_q[sel], reg_wdata_i, reg_wstrb_i);
          3'd3:    if (reg_wstrb_i[0]) conf_q[sel] <= reg_wdata_i[1:0];
          default: ;
        endcase
      end

      if (id_push) begin
        qmem[sel][q_wr[sel]] <= '{src: src_q[sel], dst: dst_q[sel], len: len_q[sel],
                                  conf: conf_q[sel], id: next_id_q[sel]};
        next_id_q[sel]       <= id_inc(next_id_q[sel]);
      end

      for (int c = 0; c < NumChannels; c++) begin
        if (q_push[c]) q_wr[c] <= q_inc(q_wr[c]);
        if (q_pop[c])  q_rd[c] <= q_inc(q_rd[c]);
        case ({q_push[c], q_pop[c]})
          2'b10:   q_cnt[c] <= q_cnt[c] + QCntW'(1);
          2'b01:   q_cnt[c] <= q_cnt[c] - QCntW'(1);
          default: ;
        endcase
      end

      // Completion frees the oldest slot; a handshake only lands on a free one.
      if (cpl) begin
        f_vld[f_rd]        <= 1'b0;
        f_rd               <= f_inc(f_rd);
        done_q[f_ch[f_rd]] <= id_inc(done_q[f_ch[f_rd]]);
      end
      if (hs) begin
        f_ch[f_wr]  <= gnt_ch;
        f_vld[f_wr] <= 1'b1;
        f_wr        <= f_inc(f_wr);
        rr_ptr      <= (gnt_ch == ChW'(NumChannels - 1)) ? '0 : gnt_ch + ChW'(1);
      end
      case ({hs, cpl})
        2'b10:   f_cnt <= f_cnt + FCntW'(1);
        2'b01:   f_cnt <= f_cnt - FCntW'(1);
        default: ;
      endcase

      hold_q    <= burst_valid_o && !burst_ready_i;
      hold_ch_q <= gnt_ch;
    end
  end
endmodule

// File: tb/tb_idma_reg_mchan_frontend.sv
// Directed bench for idma_reg_mchan_frontend: register vector table plus sequences
// for queueing, round-robin, in-flight limit, ID wrap and reset.
module tb_idma_reg_mchan_frontend;
  localparam int NCh = 4;
  localparam int QD  = 2;
  localparam int IFD = 4;
  localparam int IDW = 4;

  logic           clk = 1'b0;
  logic           rst_i = 1'b1;
  logic           reg_valid_i = 1'b0;
  logic           reg_write_i = 1'b0;
  logic [11:0]    reg_addr_i = '0;
  logic [63:0]    reg_wdata_i = '0;
  logic [7:0]     reg_wstrb_i = '0;
  logic [63:0]    reg_rdata_o;
  logic           reg_error_o;
  logic           reg_ready_o;
  logic           burst_valid_o;
  logic           burst_ready_i = 1'b0;
  logic [63:0]    burst_src_addr_o;
  logic [63:0]    burst_dst_addr_o;
  logic [63:0]    burst_length_o;
  logic           burst_decouple_o;
  logic           burst_deburst_o;
  logic [3:0]     burst_axi_id_o;
  logic           trans_complete_i = 1'b0;
  logic [NCh-1:0] busy_o;

  idma_reg_mchan_frontend #(
    .NumChannels(NCh), .QueueDepth(QD), .InflightDepth(IFD), .IdWidth(IDW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_wstrb_i(reg_wstrb_i),
    .reg_rdata_o(reg_rdata_o), .reg_error_o(reg_error_o), .reg_ready_o(reg_ready_o),
    .burst_valid_o(burst_valid_o), .burst_ready_i(burst_ready_i),
    .burst_src_addr_o(burst_src_addr_o), .burst_dst_addr_o(burst_dst_addr_o),
    .burst_length_o(burst_length_o), .burst_decouple_o(burst_decouple_o),
    .burst_deburst_o(burst_deburst_o), .burst_axi_id_o(burst_axi_id_o),
    .trans_complete_i(trans_complete_i), .busy_o(busy_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: all start and end 1 ns after a rising edge
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cycles(2);
    rst_i = 1'b0;
  endtask

  task automatic reg_access(input logic wr, input logic [11:0] addr, input logic [63:0] wdata,
                            input logic [7:0] strb, output logic [63:0] rdata, output logic err);
    reg_valid_i = 1'b1;
    reg_write_i = wr;
    reg_addr_i  = addr;
    reg_wdata_i = wdata;
    reg_wstrb_i = strb;
    #1;
    rdata = reg_rdata_o;
    err   = reg_error_o;
    @(posedge clk);
    #1;
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
  endtask

  task automatic reg_wr(input logic [11:0] addr, input logic [63:0] data);
    logic [63:0] rd;
    logic        e;
    reg_access(1'b1, addr, data, 8'hFF, rd, e);
  endtask

  task automatic reg_rd_check(input string name, input logic [11:0] addr, input logic [63:0] exp);
    logic [63:0] rd;
    logic        e;
    reg_access(1'b0, addr, '0, '0, rd, e);
    check(name, rd, exp);
  endtask

  task automatic pulse_complete();
    trans_complete_i = 1'b1;
    @(posedge clk);
    #1;
    trans_complete_i = 1'b0;
  endtask

  task automatic add_vec(input logic wr, input logic [11:0] addr, input logic [63:0] wdata,
                         input logic [7:0] strb, input logic [63:0] exp_rdata,
                         input logic exp_err, input string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
    vq.push_back(v);
  endtask

  // scoreboard: grant order on every handshake, and stability while valid waits for ready
  logic        pend = 1'b0;
  logic [3:0]  pend_id = '0;
  logic [63:0] pend_src = '0;

  always @(negedge clk) begin
    if (rst_i) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("hold_valid", burst_valid_o, 1);
        check("hold_axi_id", burst_axi_id_o, pend_id);
        check("hold_src", burst_src_addr_o, pend_src);
      end
      if (burst_valid_o && burst_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_burst: got axi_id %0d, expected no burst", burst_axi_id_o);
        end else begin
          check("grant_order", burst_axi_id_o, exp_q.pop_front());
        end
      end
      pend     = burst_valid_o && !burst_ready_i;
      pend_id  = burst_axi_id_o;
      pend_src = burst_src_addr_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rd;
    logic        e;

    cycles(3);
    rst_i = 1'b0;
    check("rst_valid", burst_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ready", reg_ready_o, 1);

    add_vec(1, 12'h000, 64'h1122334455667788, 8'hFF, 64'h0, 0, "src_write");
    add_vec(0, 12'h000, 64'h0, 8'h00, 64'h1122334455667788, 0, "src_read");
    add_vec(1, 12'h000, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 0, "src_strb_write");
    add_vec(0, 12'h000, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 0, "src_strb_read");
    add_vec(1, 12'h008, 64'h0123456789ABCDEF, 8'h81, 64'h0, 0, "dst_strb_write");
    add_vec(0, 12'h008, 64'h0, 8'h00, 64'h01000000000000EF, 0, "dst_strb_read");
    add_vec(1, 12'h030, 64'h5, 8'hFF, 64'h0, 1, "ro_done_write");
    add_vec(0, 12'h030, 64'h0, 8'h00, 64'h0, 0, "done_unchanged");
    add_vec(1, 12'h100, 64'hDEADBEEF, 8'hFF, 64'h0, 1, "bad_chan_write");
    add_vec(0, 12'h000, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 0, "no_alias");
    add_vec(0, 12'h100, 64'h0, 8'h00, 64'h0, 1, "bad_chan_read");
    add_vec(0, 12'h004, 64'h0, 8'h00, 64'h0, 1, "misaligned_read");
    add_vec(1, 12'h00C, 64'h1, 8'hFF, 64'h0, 1, "misaligned_write");
    add_vec(0, 12'h038, 64'h0, 8'h00, 64'h0, 1, "unmapped_read");
    add_vec(1, 12'h028, 64'h1, 8'hFF, 64'h0, 1, "ro_next_id_write");
    add_vec(1, 12'h020, 64'h1, 8'hFF, 64'h0, 1, "ro_status_write");
    add_vec(0, 12'h020, 64'h0, 8'h00, 64'h0, 0, "status_empty");
    add_vec(0, 12'h068, 64'h0, 8'h00, 64'h0, 0, "next_id_zero_len");
    add_vec(0, 12'h060, 64'h0, 8'h00, 64'h0, 0, "status_no_push");
    add_vec(1, 12'h058, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 0, "conf_write");
    add_vec(0, 12'h058, 64'h0, 8'h00, 64'h3, 0, "conf_read");

    for (int i = 0; i < vq.size(); i++) begin
      reg_access(vq[i].wr, vq[i].addr, vq[i].wdata, vq[i].strb, rd, e);
      check({vq[i].name, "_rdata"}, rd, vq[i].exp_rdata);
      check({vq[i].name, "_err"}, e, vq[i].exp_err);
    end

    // single transfer on ch0
    burst_ready_i = 1'b1;
    reg_wr(12'h000, 64'h1000);
    reg_wr(12'h008, 64'h2000);
    reg_wr(12'h010, 64'h40);
    exp_q.push_back(4'd0);
    reg_rd_check("c0_next_id", 12'h028, 64'd1);
    check("c0_valid", burst_valid_o, 1);
    check("c0_axi_id", burst_axi_id_o, 0);
    check("c0_src", burst_src_addr_o, 64'h1000);
    check("c0_dst", burst_dst_addr_o, 64'h2000);
    check("c0_len", burst_length_o, 64'h40);
    check("c0_decouple", burst_decouple_o, 0);
    cycles(1);
    pulse_complete();
    reg_rd_check("c0_done", 12'h030, 64'd1);
    check("c0_idle", busy_o, 0);

    // ch1 queue fills while the backend stalls
    burst_ready_i = 1'b0;
    reg_wr(12'h050, 64'h80);
    reg_rd_check("c1_id_a", 12'h068, 64'd1);
    reg_rd_check("c1_id_b", 12'h068, 64'd2);
    reg_access(1'b0, 12'h068, '0, '0, rd, e);
    check("c1_id_full", rd, 64'd0);
    check("c1_id_full_err", e, 0);
    reg_rd_check("c1_status", 12'h060, 64'h121);
    check("c1_axi_id", burst_axi_id_o, 1);
    check("c1_decouple", burst_decouple_o, 1);
    check("c1_deburst", burst_deburst_o, 1);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd1);
    burst_ready_i = 1'b1;
    cycles(2);
    burst_ready_i = 1'b0;
    pulse_complete();
    pulse_complete();
    reg_rd_check("c1_done", 12'h070, 64'd2);

    // round-robin over all channels, then the in-flight limit
    reg_wr(12'h090, 64'h10);
    reg_wr(12'h0D0, 64'h20);
    reg_rd_check("c0_id2", 12'h028, 64'd2);
    reg_rd_check("c1_id3", 12'h068, 64'd3);
    reg_rd_check("c2_id1", 12'h0A8, 64'd1);
    reg_rd_check("c3_id1", 12'h0E8, 64'd1);
    check("rr_busy_all", busy_o, 4'hF);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd3);
    burst_ready_i = 1'b1;
    cycles(4);
    check("inflight_full_valid", burst_valid_o, 0);
    reg_rd_check("c2_requeue_id", 12'h0A8, 64'd2);
    cycles(2);
    check("inflight_block", burst_valid_o, 0);
    exp_q.push_back(4'd2);
    pulse_complete();
    check("inflight_resume", burst_valid_o, 1);
    check("requeue_axi_id", burst_axi_id_o, 2);
    cycles(1);
    repeat (4) pulse_complete();
    reg_rd_check("c0_done2", 12'h030, 64'd2);
    reg_rd_check("c2_done2", 12'h0B0, 64'd2);
    reg_rd_check("c3_done1", 12'h0F0, 64'd1);
    check("all_idle", busy_o, 0);

    // ID wrap on a 4-bit ID space, then reset in the middle of traffic
    do_reset();
    check("rst2_valid", burst_valid_o, 0);
    reg_wr(12'h010, 64'h40);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(4'd0);
      reg_rd_check("wrap_id", 12'h028, 64'((i % 15) + 1));
      cycles(1);
      pulse_complete();
    end
    reg_rd_check("wrap_done", 12'h030, 64'd1);

    exp_q.push_back(4'd0);
    reg_rd_check("mid_id", 12'h028, 64'd2);
    cycles(1);
    burst_ready_i = 1'b0;
    reg_rd_check("mid_id_queued", 12'h028, 64'd3);
    check("mid_busy", busy_o, 4'h1);
    do_reset();
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_valid", burst_valid_o, 0);
    reg_rd_check("post_rst_done", 12'h030, 64'd0);
    reg_rd_check("post_rst_len", 12'h010, 64'd0);
    reg_wr(12'h010, 64'h40);
    reg_rd_check("post_rst_id", 12'h028, 64'd1);
    cycles(2);
    check("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
